// File: rtl/raizing_cen_pkg.sv
// Shared constants for the fractional clock-enable generator: default widths,
// reset ratios (channel 0 in the LSBs) and a width helper.
package raizing_cen_pkg;

   localparam int unsigned NCH_DEF = 3;
   localparam int unsigned WC_DEF  = 20;
   localparam int unsigned WD_DEF  = 2;

   localparam logic [NCH_DEF*WC_DEF-1:0] INIT_N_DEF = {20'd112, 20'd5333, 20'd1};
   localparam logic [NCH_DEF*WC_DEF-1:0] INIT_M_DEF = {20'd625, 20'd94500, 20'd7};

   // Bits needed to index v items; never less than 1 so ports stay legal.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/raizing_cen_chan.sv
// One fractional clock-enable channel: n/m phase accumulator, base/2^k divider
// taps, and a shadow ratio that is applied on the next base tick.
module raizing_cen_chan
   import raizing_cen_pkg::*;
#(
   parameter int unsigned    WC     = WC_DEF,
   parameter int unsigned    WD     = WD_DEF,
   parameter logic [WC-1:0]  INIT_N = WC'(1),
   parameter logic [WC-1:0]  INIT_M = WC'(7)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic          sync,
   input  logic          wr_en,
   input  logic [WC-1:0] wr_n,
   input  logic [WC-1:0] wr_m,
   output logic [WD-1:0] cen,
   output logic [WD-1:0] cenb
);

   localparam int unsigned DW = (WD > 1) ? WD - 1 : 1;

   logic [WC-1:0] cnt_q, cnt_d;
   logic [DW-1:0] div_q, div_d;
   logic [WC-1:0] n_q, n_d, m_q, m_d;
   logic [WC-1:0] sn_q, sn_d, sm_q, sm_d;
   logic          pend_q, pend_d;
   logic [WD-1:0] cen_q, cen_d, cenb_q, cenb_d;

   logic [WC:0]   nxt_c, half_m_c;
   logic          base_c, half_c, apply_c;
   logic [WD-1:0] tap_en_c;

   always_comb begin
      nxt_c    = {1'b0, cnt_q} + {1'b0, n_q};
      half_m_c = {1'b0, m_q >> 1};
      base_c   = run && (nxt_c >= {1'b0, m_q});
      half_c   = run && ({1'b0, cnt_q} < half_m_c) && (nxt_c >= half_m_c) && !base_c;
      apply_c  = pend_q && (!run || base_c);

      // Tap k fires only when the low k divider bits are all ones.
      tap_en_c    = '0;
      tap_en_c[0] = 1'b1;
      for (int unsigned k = 1; k < WD; k++) tap_en_c[k] = tap_en_c[k-1] & div_q[k-1];

      cnt_d  = cnt_q;
      div_d  = div_q;
      n_d    = n_q;
      m_d    = m_q;
      sn_d   = sn_q;
      sm_d   = sm_q;
      pend_d = pend_q;
      cen_d  = '0;
      cenb_d = '0;

      if (run) begin
         if (base_c) begin
            cnt_d = WC'(nxt_c - {1'b0, m_q});
            div_d = div_q + DW'(1);
            cen_d = tap_en_c;
         end else begin
            cnt_d = nxt_c[WC-1:0];
            if (half_c) cenb_d = tap_en_c;
         end
      end else begin
         cnt_d = '0;
         div_d = '0;
      end

      // Residue survives a ratio change unless it no longer fits the new m.
      if (apply_c) begin
         n_d    = sn_q;
         m_d    = sm_q;
         pend_d = 1'b0;
         if (cnt_d >= sm_q) cnt_d = '0;
      end

      if (sync) begin
         cnt_d  = '0;
         div_d  = '0;
         cen_d  = '0;
         cenb_d = '0;
      end

      if (wr_en) begin
         sn_d   = wr_n;
         sm_d   = wr_m;
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         div_q  <= '0;
         n_q    <= INIT_N;
         m_q    <= INIT_M;
         sn_q   <= INIT_N;
         sm_q   <= INIT_M;
         pend_q <= 1'b0;
         cen_q  <= '0;
         cenb_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         n_q    <= n_d;
         m_q    <= m_d;
         sn_q   <= sn_d;
         sm_q   <= sm_d;
         pend_q <= pend_d;
         cen_q  <= cen_d;
         cenb_q <= cenb_d;
      end
   end

   assign cen  = cen_q;
   assign cenb = cenb_q;

endmodule

// File: rtl/raizing_cen_gen.sv
// Multi-channel fractional clock-enable generator with a validated config
// write port and a global phase-align strobe.
module raizing_cen_gen
   import raizing_cen_pkg::*;
#(
   parameter int unsigned          NCH    = NCH_DEF,
   parameter int unsigned          WC     = WC_DEF,
   parameter int unsigned          WD     = WD_DEF,
   parameter logic [NCH*WC-1:0]    INIT_N = INIT_N_DEF,
   parameter logic [NCH*WC-1:0]    INIT_M = INIT_M_DEF
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [NCH-1:0]           RUN,
   input  logic                     SYNC,
   input  logic                     CFG_WE,
   input  logic [clog2(NCH)-1:0]    CFG_CH,
   input  logic [WC-1:0]            CFG_N,
   input  logic [WC-1:0]            CFG_M,
   output logic                     CFG_ACK,
   output logic                     CFG_ERR,
   output logic [NCH*WD-1:0]        CEN,
   output logic [NCH*WD-1:0]        CENB
);

   localparam int unsigned CW = clog2(NCH);

   logic cfg_ok_c;
   logic ack_q, ack_d, err_q, err_d;

   // A ratio must be non-zero and keep n <= m/2 so half ticks stay distinct.
   always_comb begin
      cfg_ok_c = (32'(CFG_CH) < NCH) && (CFG_N != '0) && (CFG_M != '0) &&
                 ({CFG_N, 1'b0} <= {1'b0, CFG_M});
      ack_d    = CFG_WE & cfg_ok_c;
      err_d    = CFG_WE & ~cfg_ok_c;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         ack_q <= ack_d;
         err_q <= err_d;
      end
   end

   assign CFG_ACK = ack_q;
   assign CFG_ERR = err_q;

   for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
      logic wr_sel_c;
      assign wr_sel_c = CFG_WE && cfg_ok_c && (CFG_CH == CW'(ch));

      raizing_cen_chan #(
         .WC     (WC),
         .WD     (WD),
         .INIT_N (INIT_N[ch*WC +: WC]),
         .INIT_M (INIT_M[ch*WC +: WC])
      ) u_chan (
         .clk   (CLK),
         .rst   (RESET),
         .run   (RUN[ch]),
         .sync  (SYNC),
         .wr_en (wr_sel_c),
         .wr_n  (CFG_N),
         .wr_m  (CFG_M),
         .cen   (CEN[ch*WD +: WD]),
         .cenb  (CENB[ch*WD +: WD])
      );
   end

endmodule

// File: tb/tb_raizing_cen_gen.sv
// Directed bench for raizing_cen_gen with default parameters (ch0 1/7,
// ch1 5333/94500, ch2 112/625, two taps per channel).
module tb_raizing_cen_gen;

   logic        CLK;
   logic        RESET;
   logic [2:0]  RUN;
   logic        SYNC;
   logic        CFG_WE;
   logic [1:0]  CFG_CH;
   logic [19:0] CFG_N;
   logic [19:0] CFG_M;
   logic        CFG_ACK;
   logic        CFG_ERR;
   logic [5:0]  CEN;
   logic [5:0]  CENB;

   int n_checks = 0;
   int n_errors = 0;

   raizing_cen_gen dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .RUN     (RUN),
      .SYNC    (SYNC),
      .CFG_WE  (CFG_WE),
      .CFG_CH  (CFG_CH),
      .CFG_N   (CFG_N),
      .CFG_M   (CFG_M),
      .CFG_ACK (CFG_ACK),
      .CFG_ERR (CFG_ERR),
      .CEN     (CEN),
      .CENB    (CENB)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge CLK);
   endtask

   // Seven cycles from a freshly cleared state: every channel starts at cnt=0.
   task automatic startup(input string tag);
      logic [15:0] m;
      m = '0;
      for (int i = 1; i <= 7; i++) begin
         step();
         m[i-1] = CEN[0];
         if (i == 3) begin
            check({tag, "_cen3"}, 64'(CEN), 64'h00);
            check({tag, "_cenb3"}, 64'(CENB), 64'h11);
         end
         if (i == 6) check({tag, "_cen6"}, 64'(CEN), 64'h10);
         if (i == 7) check({tag, "_cen7"}, 64'(CEN), 64'h01);
      end
      check({tag, "_ch0_mask"}, 64'(m), 64'h0040);
   endtask

   task automatic wait_cen0(input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (CEN[0]) found = 1'b1;
      end
      check({tag, "_found"}, 64'(found), 64'h1);
   endtask

   initial begin
      int c0, c1, cb0, c2, last0, last2, hb_bad, gap_bad;
      logic [15:0] m;

      RESET  = 1'b1;
      RUN    = 3'b000;
      SYNC   = 1'b0;
      CFG_WE = 1'b0;
      CFG_CH = 2'd0;
      CFG_N  = 20'd0;
      CFG_M  = 20'd0;

      // Held in reset with RUN high: nothing may move.
      step();
      step();
      RUN = 3'b111;
      step();
      check("rst_cen", 64'(CEN), 64'h0);
      check("rst_cenb", 64'(CENB), 64'h0);
      check("rst_ack", 64'(CFG_ACK), 64'h0);
      check("rst_err", 64'(CFG_ERR), 64'h0);
      RESET = 1'b0;
      startup("boot");

      // Long run: ch0 rates and half-tick offset, ch2 fractional pulse count.
      c0 = 1; c1 = 0; cb0 = 1; c2 = 1; last0 = 7; last2 = 6; hb_bad = 0; gap_bad = 0;
      for (int i = 8; i <= 62500; i++) begin
         step();
         if (i <= 7000) begin
            if (CEN[0]) begin c0++; last0 = i; end
            if (CEN[1]) c1++;
            if (CENB[0]) begin
               cb0++;
               if (i - last0 != 3) hb_bad++;
            end
         end
         if (CEN[4]) begin
            c2++;
            if (i - last2 < 5 || i - last2 > 6) gap_bad++;
            last2 = i;
         end
      end
      check("ch0_cen0_count", 64'(c0), 64'd1000);
      check("ch0_cen1_count", 64'(c1), 64'd500);
      check("ch0_cenb0_count", 64'(cb0), 64'd1000);
      check("ch0_cenb_offset_bad", 64'(hb_bad), 64'd0);
      check("ch2_cen0_count", 64'(c2), 64'd11200);
      check("ch2_gap_bad", 64'(gap_bad), 64'd0);

      // SYNC on the exact edge of a ch0 base tick.
      wait_cen0("sync_ref");
      for (int i = 0; i < 6; i++) step();
      SYNC = 1'b1;
      step();
      SYNC = 1'b0;
      check("sync_cen_cleared", 64'(CEN), 64'h0);
      check("sync_cenb_cleared", 64'(CENB), 64'h0);
      startup("sync");

      // Rejected writes: ratio > 1/2, bad channel, zero m.
      m = '0;
      CFG_WE = 1'b1; CFG_CH = 2'd0; CFG_N = 20'd4; CFG_M = 20'd7;
      step();
      m[0] = CEN[0];
      check("err_ratio", 64'(CFG_ERR), 64'h1);
      check("err_ratio_ack", 64'(CFG_ACK), 64'h0);
      CFG_CH = 2'd3; CFG_N = 20'd1; CFG_M = 20'd4;
      step();
      m[1] = CEN[0];
      check("err_chan", 64'(CFG_ERR), 64'h1);
      check("err_chan_ack", 64'(CFG_ACK), 64'h0);
      CFG_CH = 2'd0; CFG_N = 20'd1; CFG_M = 20'd0;
      step();
      m[2] = CEN[0];
      check("err_m0", 64'(CFG_ERR), 64'h1);
      check("err_m0_ack", 64'(CFG_ACK), 64'h0);
      CFG_WE = 1'b0;
      step();
      m[3] = CEN[0];
      check("err_idle", 64'(CFG_ERR), 64'h0);
      for (int i = 4; i < 7; i++) begin
         step();
         m[i] = CEN[0];
      end
      check("err_ch0_period", 64'(m), 64'h0040);

      // Accepted write two cycles into a period: 7 completes, then period 4.
      step();
      step();
      CFG_WE = 1'b1; CFG_CH = 2'd0; CFG_N = 20'd1; CFG_M = 20'd4;
      m = '0;
      step();
      CFG_WE = 1'b0;
      m[0] = CEN[0];
      check("wr_ack", 64'(CFG_ACK), 64'h1);
      check("wr_err", 64'(CFG_ERR), 64'h0);
      for (int i = 1; i <= 12; i++) begin
         step();
         m[i] = CEN[0];
      end
      check("wr_ch0_periods", 64'(m), 64'h1110);

      // Asynchronous reset between edges while a pulse is on the outputs.
      check("pre_rst_cen0", 64'(CEN[0]), 64'h1);
      #2 RESET = 1'b1;
      #1;
      check("arst_cen", 64'(CEN), 64'h0);
      check("arst_cenb", 64'(CENB), 64'h0);
      check("arst_ack", 64'(CFG_ACK), 64'h0);
      check("arst_err", 64'(CFG_ERR), 64'h0);
      step();
      RESET = 1'b0;
      startup("rerun");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/raizing_cen_gen.md
RAIZING_CEN_GEN -- requirements
Module: raizing_cen_gen

Interface
REQ-001 SHALL have parameter NCH, default 3: number of independent fractional clock-enable channels.
REQ-002 SHALL have parameter WC, default 20: accumulator, n and m width.
REQ-003 SHALL have parameter WD, default 2: divided taps per channel; tap k runs at base/2^k.
REQ-004 SHALL have parameter INIT_N, default {112,5333,1}, packed NCH*WC (channel 0 in the LSBs): reset numerators.
REQ-005 SHALL have parameter INIT_M, default {625,94500,7}, packed NCH*WC: reset denominators.
REQ-006 SHALL have port CLK, input, 1: the single clock.
REQ-007 SHALL have port RESET, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port RUN, input, NCH: per-channel run enable.
REQ-009 SHALL have port SYNC, input, 1: one-cycle pulse that phase-aligns all channels.
REQ-010 SHALL have port CFG_WE, input, 1: config write strobe.
REQ-011 SHALL have port CFG_CH, input, clog2(NCH): target channel.
REQ-012 SHALL have ports CFG_N and CFG_M, input, WC each: new ratio.
REQ-013 SHALL have ports CFG_ACK and CFG_ERR, output, 1 each: write accepted / write rejected.
REQ-014 SHALL have ports CEN and CENB, output, NCH*WD each: bit ch*WD+k is channel ch, tap k.

Function
REQ-015 Each cycle with RUN[ch]=1, channel SHALL compute nxt=cnt+n in WC+1 bits; if nxt>=m then cnt<=nxt-m and base tick, else cnt<=nxt.
REQ-016 Half tick SHALL fire when cnt<floor(m/2), nxt>=floor(m/2) and no base tick fires that cycle.
REQ-017 Each channel SHALL hold a WD-1 bit divider counter div, incremented on base tick and wrapping.
REQ-018 CEN[ch,k] SHALL be a registered one-cycle pulse on base tick when div[k-1:0] are all ones (k=0: every base tick); CENB[ch,k] likewise on half tick.
REQ-019 CEN/CENB SHALL be registered on the same edge that updates cnt: one cycle latency from the crossing.
REQ-020 A write SHALL be rejected (CFG_ERR pulse next cycle, no state change) if CFG_CH>=NCH, CFG_N=0, CFG_M=0 or 2*CFG_N>CFG_M.
REQ-021 An accepted write SHALL pulse CFG_ACK next cycle and load the channel's shadow {n,m} with a pending flag; a later write before apply overwrites it (last wins).
REQ-022 Pending config on a running channel SHALL apply on the edge of its next base tick; the residue is kept, except it SHALL be cleared to 0 if >= new m.
REQ-023 Pending config on a stopped channel SHALL apply on the next edge with cnt and div cleared.
REQ-024 RUN[ch]=0 SHALL force that channel's CEN/CENB to 0 from the next cycle and clear cnt and div.
REQ-025 SYNC SHALL clear cnt, div and output pulses of all channels on the next edge; SYNC wins over a simultaneous tick (no pulse issued) but not over a simultaneous config apply (config still applies).
REQ-026 Accepted writes SHALL be taken every cycle; no back-pressure.

Reset
REQ-027 RESET SHALL immediately force CEN, CENB, CFG_ACK, CFG_ERR, cnt, div and pending flags to 0, and load n/m from INIT_N/INIT_M.
REQ-028 After RESET deasserts, the first CEN SHALL occur no earlier than ceil(m/n) cycles later with RUN high.

Structure
REQ-029 Shared package raizing_cen_pkg SHALL hold default WC/WD, the reset-ratio constants and a clog2 function.
REQ-030 Per-channel logic SHALL be one sub-module raizing_cen_chan (accumulator, divider, shadow config), instantiated NCH times by generate.

Verification
REQ-031 Reset, RUN=all, ch0 1/7, WD=2 -> CEN[0] period 7, CEN[1] period 14, CENB[0] 3 cycles after each CEN[0]; 7000 cycles give 1000/500 pulses.
REQ-032 ch2 112/625, 62500 cycles -> exactly 11200 CEN[ch2,0] pulses, spacing 5 or 6 only.
REQ-033 Write ch0 n=1 m=4 mid-period -> CFG_ACK next cycle; current 7-cycle period completes, then period 4.
REQ-034 Writes ch0 n=4 m=7, CFG_CH=3, m=0 -> CFG_ERR each, CFG_ACK 0, ch0 period unchanged.
REQ-035 SYNC coincident with ch0 tick -> no pulse that cycle; next ch0 CEN exactly 7 cycles later, all channels restart aligned.
REQ-036 RESET asserted mid-run, asynchronously off-edge -> all outputs 0 before next edge; INIT ratios restored after release.
